// File: rtl/reimu_shot_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shot_pkg
// Brief    : Shared constants and FSM state type for the Reimu shot scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package shot_pkg;

    localparam int SHOT_W = 10;

    // Speed bands: y <= BAND1 moves slow, y <= BAND2 moves mid, above that fast.
    localparam logic [SHOT_W-1:0] SHOT_Y_BAND1   = 10'd120;
    localparam logic [SHOT_W-1:0] SHOT_Y_BAND2   = 10'd240;
    localparam logic [SHOT_W-1:0] SHOT_STEP_SLOW = 10'd1;
    localparam logic [SHOT_W-1:0] SHOT_STEP_MID  = 10'd4;
    localparam logic [SHOT_W-1:0] SHOT_STEP_FAST = 10'd5;

    typedef enum logic [0:0] {
        READY = 1'b0,
        COOL  = 1'b1
    } shot_state_e;

endpackage : shot_pkg
`default_nettype wire

// File: rtl/reimu_shot_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : reimu_shot_sched_if
// Brief    : Control inputs and flattened slot outputs of the shot scheduler.
//            The hit vector exists only when SHOT_HIT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface reimu_shot_sched_if
    import shot_pkg::*;
#(
    parameter int NSLOT = 4
);
    logic                    tick;
    logic                    fire;
    logic [SHOT_W-1:0]       reimux;
    logic [SHOT_W-1:0]       reimuy;
`ifdef SHOT_HIT_EN
    logic [NSLOT-1:0]        hit;
`endif
    logic [NSLOT*SHOT_W-1:0] shot_x;
    logic [NSLOT*SHOT_W-1:0] shot_y;
    logic [NSLOT-1:0]        shot_vld;
    logic                    ready;

    modport master (
`ifdef SHOT_HIT_EN
        output hit,
`endif
        output tick, fire, reimux, reimuy,
        input  shot_x, shot_y, shot_vld, ready
    );

    modport slave (
`ifdef SHOT_HIT_EN
        input  hit,
`endif
        input  tick, fire, reimux, reimuy,
        output shot_x, shot_y, shot_vld, ready
    );

endinterface : reimu_shot_sched_if
`default_nettype wire

// File: rtl/reimu_shot_sched_slot.sv
`default_nettype none
// ============================================================================
// Module   : shot_slot
// Brief    : One bullet slot: position/valid registers, band step select,
//            top-exit detect and hit > launch > advance priority.
// Revision : 1.0 - initial release
// ============================================================================
module shot_slot
    import shot_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              tick_i,
    input  wire logic              launch_i,
    input  wire logic              hit_i,
    input  wire logic [SHOT_W-1:0] x_i,
    input  wire logic [SHOT_W-1:0] y_i,
    output logic      [SHOT_W-1:0] x_o,
    output logic      [SHOT_W-1:0] y_o,
    output logic                   vld_o
);

    logic [SHOT_W-1:0] x_q;
    logic [SHOT_W-1:0] y_q;
    logic              vld_q;
    logic [SHOT_W-1:0] w_step;
    logic              w_exit;

    always_comb begin
        w_step = SHOT_STEP_FAST;
        if (y_q <= SHOT_Y_BAND1) begin
            w_step = SHOT_STEP_SLOW;
        end else if (y_q <= SHOT_Y_BAND2) begin
            w_step = SHOT_STEP_MID;
        end
    end

    // Subtracting would wrap, so the shot has left the top of the screen.
    assign w_exit = (y_q < w_step) || (y_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            vld_q <= 1'b0;
        end else if (hit_i && vld_q) begin
            vld_q <= 1'b0;
        end else if (launch_i) begin
            x_q   <= x_i;
            y_q   <= y_i;
            vld_q <= 1'b1;
        end else if (tick_i && vld_q) begin
            if (w_exit) begin
                vld_q <= 1'b0;
            end else begin
                y_q <= y_q - w_step;
            end
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign vld_o = vld_q;

endmodule : shot_slot
`default_nettype wire

// File: rtl/reimu_shot_sched.sv
`default_nettype none
// ============================================================================
// Module   : reimu_shot_sched
// Brief    : Player-shot scheduler: slot allocation, launch cooldown FSM and
//            NSLOT bullet slots. Define SHOT_HIT_EN to enable hit retire.
// Revision : 1.0 - initial release
// ============================================================================
module reimu_shot_sched
    import shot_pkg::*;
#(
    parameter int NSLOT    = 4,
    parameter int COOLDOWN = 8
)(
    input  wire logic          clk_22,
    input  wire logic          rst_n,
    reimu_shot_sched_if.slave  bus
);

    localparam logic [7:0] c_cd_load = 8'(COOLDOWN - 1);

    shot_state_e      state_q;
    logic [7:0]       cd_q;
    logic             ready_q;
    logic [NSLOT-1:0] w_free;
    logic [NSLOT-1:0] w_alloc;
    logic [NSLOT-1:0] w_launch;
    logic [NSLOT-1:0] w_hit;
    logic             w_fire_ok;

    // Isolate the lowest set bit: lowest-index free slot, from pre-tick valids.
    assign w_free    = ~bus.shot_vld;
    assign w_alloc   = w_free & (~w_free + NSLOT'(1));
    assign w_fire_ok = (state_q == READY) && bus.tick && bus.fire && (|w_free);
    assign w_launch  = w_fire_ok ? w_alloc : '0;

`ifdef SHOT_HIT_EN
    assign w_hit = bus.hit;
`else
    assign w_hit = '0;
`endif

    always_ff @(posedge clk_22 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= READY;
            cd_q    <= '0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                READY: begin
                    if (w_fire_ok) begin
                        state_q <= COOL;
                        cd_q    <= c_cd_load;
                        ready_q <= 1'b0;
                    end
                end
                COOL: begin
                    if (bus.tick) begin
                        if (cd_q != '0) begin
                            cd_q <= cd_q - 8'd1;
                        end else begin
                            state_q <= READY;
                            ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;

    generate
        for (genvar i = 0; i < NSLOT; i++) begin : g_slot
            shot_slot u_slot (
                .clk      (clk_22),
                .rst_n    (rst_n),
                .tick_i   (bus.tick),
                .launch_i (w_launch[i]),
                .hit_i    (w_hit[i]),
                .x_i      (bus.reimux),
                .y_i      (bus.reimuy),
                .x_o      (bus.shot_x[i*SHOT_W +: SHOT_W]),
                .y_o      (bus.shot_y[i*SHOT_W +: SHOT_W]),
                .vld_o    (bus.shot_vld[i])
            );
        end
    endgenerate

endmodule : reimu_shot_sched
`default_nettype wire

// File: tb/tb_reimu_shot_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_reimu_shot_sched
// Brief    : Self-checking bench for reimu_shot_sched against a slot/cooldown
//            reference model. Hit scenarios are built only with SHOT_HIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reimu_shot_sched;

    localparam int NS = 4;
    localparam int CD = 8;

    logic clk_22 = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_22 = ~clk_22;

    reimu_shot_sched_if #(.NSLOT(NS)) bus();

    reimu_shot_sched #(.NSLOT(NS), .COOLDOWN(CD)) dut (
        .clk_22 (clk_22),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: positions, live flags and ticks still to wait before
    // the scheduler will accept another launch.
    int mx[NS];
    int my[NS];
    bit mv[NS];
    int mwait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int step_of(input int y);
        if (y <= 120) return 1;
        if (y <= 240) return 4;
        return 5;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            mx[i] = 0; my[i] = 0; mv[i] = 1'b0;
        end
        mwait = 0;
    endtask

    task automatic model_cycle(input bit t, input bit f, input int x, input int y,
                               input logic [NS-1:0] h);
        int li;
        int s;
        li = -1;
        if (t && f && mwait == 0) begin
            for (int i = NS - 1; i >= 0; i--) if (!mv[i]) li = i;
        end
        for (int i = 0; i < NS; i++) begin
            if (h[i] && mv[i]) begin
                mv[i] = 1'b0;
            end else if (i == li) begin
                mx[i] = x; my[i] = y; mv[i] = 1'b1;
            end else if (t && mv[i]) begin
                s = step_of(my[i]);
                if (my[i] < s) mv[i] = 1'b0;
                else           my[i] = my[i] - s;
            end
        end
        if (li >= 0)              mwait = CD;
        else if (t && mwait > 0)  mwait = mwait - 1;
    endtask

    task automatic check_all();
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("vld%0d", i), 32'(bus.shot_vld[i]), 32'(mv[i]));
            chk($sformatf("x%0d", i), 32'(bus.shot_x[i*10 +: 10]), 32'(mx[i]));
            chk($sformatf("y%0d", i), 32'(bus.shot_y[i*10 +: 10]), 32'(my[i]));
        end
        chk("ready", 32'(bus.ready), 32'(mwait == 0));
    endtask

    task automatic cyc(input bit t, input bit f, input int x, input int y,
                       input logic [NS-1:0] h);
        @(negedge clk_22);
        bus.tick   = t;
        bus.fire   = f;
        bus.reimux = x[9:0];
        bus.reimuy = y[9:0];
`ifdef SHOT_HIT_EN
        bus.hit    = h;
`endif
        @(posedge clk_22);
        model_cycle(t, f, x, y, h);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk_22);
        rst_n      = 1'b0;
        bus.tick   = 1'b0;
        bus.fire   = 1'b0;
        bus.reimux = '0;
        bus.reimuy = '0;
`ifdef SHOT_HIT_EN
        bus.hit    = '0;
`endif
        model_reset();
        #1;
        check_all();
        @(negedge clk_22);
        rst_n = 1'b1;
    endtask

    initial begin
        int ysave;
        logic [NS-1:0] h;
        bus.tick = 1'b0; bus.fire = 1'b0; bus.reimux = '0; bus.reimuy = '0;
`ifdef SHOT_HIT_EN
        bus.hit  = '0;
`endif
        model_reset();

        // Reset then a single launch from (100,400).
        do_reset();
        chk("rst_ready", 32'(bus.ready), 32'd1);
        cyc(1, 1, 100, 400, '0);
        chk("launch_x0", 32'(bus.shot_x[9:0]), 32'd100);
        chk("launch_y0", 32'(bus.shot_y[9:0]), 32'd400);
        chk("launch_vld", 32'(bus.shot_vld), 32'h1);
        chk("launch_ready", 32'(bus.ready), 32'd0);

        // Speed bands: launch at 245 and fly until it leaves the top.
        do_reset();
        cyc(1, 1, 50, 245, '0);
        for (int k = 0; k < 160; k++) begin
            cyc(1, 0, 0, 0, '0);
            if (k == 0)  chk("band_first", 32'(bus.shot_y[9:0]), 32'd240);
            if (k == 1)  chk("band_mid",   32'(bus.shot_y[9:0]), 32'd236);
            if (k == 31) chk("band_slow",  32'(bus.shot_y[9:0]), 32'd119);
        end
        chk("band_exit_vld", 32'(bus.shot_vld[0]), 32'd0);

        // Cooldown with fire held: launches on ticks 0, 9, 18, 27.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            cyc(1, 1, 10 * k, 1000, '0);
            if (k == 26) chk("cool_t26", 32'(bus.shot_vld), 32'h7);
            if (k == 27) chk("cool_t27", 32'(bus.shot_vld), 32'hF);
        end

        // Pool full; slot2 launched low so it exits first and is refilled.
        do_reset();
        for (int k = 0; k < 90; k++) begin
            cyc(1, 1, k, (k == 18) ? 60 : 1000, '0);
            if (k == 40) chk("full_ready", 32'(bus.ready), 32'd1);
            if (k == 79) chk("full_slot2_free", 32'(bus.shot_vld), 32'hB);
            if (k == 80) chk("full_slot2_relaunch", 32'(bus.shot_x[29:20]), 32'd80);
        end

`ifdef SHOT_HIT_EN
        // Hit beats advance on the same tick; hit on an empty slot is ignored.
        do_reset();
        for (int k = 0; k < 12; k++) cyc(1, (k < 10) ? 1'b1 : 1'b0, k, 500, '0);
        ysave = my[1];
        cyc(1, 0, 0, 0, 4'b1010);
        chk("hit_vld1", 32'(bus.shot_vld[1]), 32'd0);
        chk("hit_y1", 32'(bus.shot_y[19:10]), 32'(ysave));
        cyc(0, 0, 0, 0, 4'b0001);
        chk("hit_offtick", 32'(bus.shot_vld), 32'h0);
`endif

        // Asynchronous reset between edges with three live slots.
        do_reset();
        for (int k = 0; k < 20; k++) cyc(1, 1, k, 900, '0);
        chk("pre_areset_vld", 32'(bus.shot_vld), 32'h7);
        @(negedge clk_22);
        bus.tick = 1'b0;
        bus.fire = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_vld", 32'(bus.shot_vld), 32'h0);
        chk("areset_ready", 32'(bus.ready), 32'd1);
        check_all();
        @(negedge clk_22);
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            h = '0;
`ifdef SHOT_HIT_EN
            if ($urandom_range(0, 7) == 0) h = NS'($urandom);
`endif
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), h);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reimu_shot_sched
`default_nettype wire

// File: doc/reimu_shot_sched.md
# reimu_shot_sched

Player-shot scheduler for the Reimu ship: owns a small pool of bullet slots. On the frame tick it launches new shots from the ship position under a cooldown, advances every live shot with the three-band speed profile, and retires shots that leave the top of the screen or are reported as hits. It sits between the input/ship-position logic and the collision and VGA draw logic, which consume the flattened slot positions and valid flags.

## Interface
Parameters:
- `NSLOT`, 4 — number of bullet slots (1..8).
- `COOLDOWN`, 8 — ticks between successive launches (1..255).

Ports:
- `clk_22` in 1 — system clock.
- `rst_n` in 1 — reset, **asynchronous, active-low**.
- `tick` in 1 — one-cycle frame-step pulse; all motion and launch happen only on cycles where `tick` is high.
- `fire` in 1 — level; high while the shoot button is held.
- `reimux` in 10 — ship x.
- `reimuy` in 10 — ship y.
- `hit` in NSLOT — per-slot retire request from collision logic; only present with `SHOT_HIT_EN`.
- `shot_x` out NSLOT*10 — slot i x in bits [10i+9:10i].
- `shot_y` out NSLOT*10 — slot i y, same packing.
- `shot_vld` out NSLOT — slot i is live.
- `ready` out 1 — the launch FSM is in READY.

## Operation
- Launch FSM, two states:
  - READY: on `tick & fire`, if any slot is free, launch into it and go to COOL.
    - If no slot is free, stay in READY; there is no launch and no cooldown.
  - COOL: on entry, `cd_cnt` is loaded with `COOLDOWN-1`.
    - Each `tick` with `cd_cnt!=0`: decrement `cd_cnt`.
    - `tick` with `cd_cnt==0`: go to READY. A launch can happen on the next tick, not on this one.
- Launch:
  - The lowest-index slot with `shot_vld==0`, sampled before this tick's updates, is the one allocated.
  - `shot_x <= reimux`, `shot_y <= reimuy`, `shot_vld <= 1`.
  - A freshly launched slot does not move on its launch tick.
- Advance: on `tick`, each live slot not launched this tick updates by step s:
  - y ≤ 120 → s=1.
  - 121..240 → s=4.
  - y ≥ 241 → s=5.
  - If y < s, or y == 0: clear `shot_vld` (exited the top); x/y hold their last value.
  - Otherwise `shot_y <= y - s`. x never changes.
  - All arithmetic is unsigned 10-bit; no wrap is ever stored.
- Hit retire (`SHOT_HIT_EN`): `hit[i]` is sampled every cycle, not only on ticks.
  - If `shot_vld[i]`, clear it.
  - Hit takes priority over advance in the same cycle.
  - `hit` on an invalid slot is ignored.
- A slot that retires on a tick (hit or top exit) becomes free for allocation on the following tick only.

## Timing
- Reset values:
  - `shot_vld=0`.
  - `shot_x=0`, `shot_y=0`.
  - FSM=READY, `ready=1`, `cd_cnt=0`.
- All outputs are registered.
  - Launch or advance on the `tick` cycle is visible on the next cycle.
  - `hit[i]` clears `shot_vld[i]` on the next cycle.
- `rst_n` asserted mid-flight clears all slots and the FSM immediately, with no clock needed.
- Launch rate with `fire` held: one shot per `COOLDOWN+1` ticks.

## Configuration
- `SHOT_HIT_EN` defined:
  - The `hit` port exists.
  - Hit retire works as described above.
- Not defined:
  - The `hit` port is removed.
  - Slots retire only by top-of-screen exit.
  - All other behaviour is identical.

## Structure
- Package `shot_pkg` holds:
  - Band thresholds `SHOT_Y_BAND1=120` and `SHOT_Y_BAND2=240`.
  - Steps `SHOT_STEP_SLOW=1`, `SHOT_STEP_MID=4`, `SHOT_STEP_FAST=5`.
  - Coordinate width `SHOT_W=10`.
  - FSM state type `{READY, COOL}`.
- Sub-module `shot_slot` is instantiated NSLOT times.
  - It holds the x/y/vld registers, the step select, the exit detect and the hit/launch priority.
- The top level keeps the priority encoder for allocation, the FSM and the cooldown counter.

## Test plan
- **Reset then launch.** Reset; `fire=1`; ship (100,400); one tick.
  - Slot0 = (100,400), valid.
  - `ready=0`.
  - Slots 1..3 stay invalid.
- **Speed bands.** Launch at y=245, then apply ticks.
  - y goes 240 → 236 → … → 120 → 119 → … → 0.
  - The next tick clears valid.
- **Cooldown.** `COOLDOWN=8`, `fire` held for 30 ticks.
  - Launches occur on ticks 0, 9, 18 and 27, into slots 0..3 in order.
- **Pool full.** Hold `fire` until all 4 slots are live.
  - Further ticks launch nothing and the FSM stays READY.
  - Retire slot2; the launch occurs into slot2 on the tick after the retire.
- **Hit beats advance** (`SHOT_HIT_EN`). `hit[1]` and `tick` arrive in the same cycle.
  - Slot1 is invalid next cycle and its y is unchanged.
  - `hit[3]` on an empty slot 3 has no effect.
- **Async reset mid-flight.** Assert `rst_n=0` between clock edges with 3 live slots.
  - All valid bits clear before the next edge.
  - FSM=READY.
